acc_c_dispatch: RTL and testbench

ACC_C_DISPATCH -- requirements
Module: acc_c_dispatch

---
 rtl/acc_c_dispatch.sv | 123 ++++++++++++
 tb/tb_acc_c_dispatch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_c_dispatch.sv
// acc_c_dispatch: queues C requests in a small FIFO, issues them in order to NumAcc ports
// with per-port outstanding limits, and merges responses round-robin into one output register.
module acc_c_dispatch #(
   parameter int NumAcc    = 4,
   parameter int AddrWidth = 3,
   parameter int ReqWidth  = 96,
   parameter int RspWidth  = 69,
   parameter int Depth     = 2,
   parameter int MaxOutst  = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       slv_q_valid_i,
   output logic                       slv_q_ready_o,
   input  logic [AddrWidth-1:0]       slv_q_addr_i,
   input  logic [ReqWidth-1:0]        slv_q_payload_i,
   output logic                       slv_p_valid_o,
   input  logic                       slv_p_ready_i,
   output logic [RspWidth-1:0]        slv_p_payload_o,
   output logic                       slv_p_err_o,
   output logic [NumAcc-1:0]          mst_q_valid_o,
   input  logic [NumAcc-1:0]          mst_q_ready_i,
   output logic [ReqWidth-1:0]        mst_q_payload_o,
   input  logic [NumAcc-1:0]          mst_p_valid_i,
   output logic [NumAcc-1:0]          mst_p_ready_o,
   input  logic [NumAcc*RspWidth-1:0] mst_p_payload_i
);
   localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);
   localparam int IdxW = $clog2(NumAcc);

   logic [AddrWidth-1:0] r_addr [Depth];
   logic [ReqWidth-1:0]  r_data [Depth];
   logic [PtrW-1:0]      r_wr, r_rd;
   logic [CntW-1:0]      r_cnt;
   logic                 r_live;
   logic [3:0]           r_outst [NumAcc];
   logic [IdxW-1:0]      r_rr;
   logic                 r_p_valid, r_p_err;
   logic [RspWidth-1:0]  r_p_payload;

   logic                 w_empty, w_push, w_pop, w_legal, w_local, w_out_free, w_issue, w_grant;
   logic [AddrWidth-1:0] w_head_addr;
   logic [IdxW-1:0]      w_head_idx, w_win;
   logic [NumAcc-1:0]    w_cand;

   // r_live keeps the request side closed until the first edge after reset release
   assign w_empty         = r_cnt == '0;
   assign slv_q_ready_o   = r_live && (r_cnt != CntW'(Depth));
   assign w_push          = slv_q_valid_i && slv_q_ready_o;
   assign w_head_addr     = r_addr[r_rd];
   assign w_legal         = {1'b0, w_head_addr} < (AddrWidth+1)'(NumAcc);
   assign w_head_idx      = w_head_addr[IdxW-1:0];
   assign w_out_free      = !r_p_valid || slv_p_ready_i;
   assign w_local         = !w_empty && !w_legal && w_out_free;
   assign w_issue         = |(mst_q_valid_o & mst_q_ready_i);
   assign w_pop           = w_issue || w_local;
   assign mst_q_payload_o = r_data[r_rd];
   assign slv_p_valid_o   = r_p_valid;
   assign slv_p_err_o     = r_p_err;
   assign slv_p_payload_o = r_p_payload;

   always_comb begin
      mst_q_valid_o = '0;
      if (!w_empty && w_legal && r_outst[w_head_idx] < 4'(MaxOutst)) mst_q_valid_o[w_head_idx] = 1'b1;
   end

   // scan from highest offset down so the candidate nearest the pointer wins
   always_comb begin
      w_cand  = '0;
      w_win   = r_rr;
      w_grant = 1'b0;
      for (int i = 0; i < NumAcc; i++) w_cand[i] = mst_p_valid_i[i] && r_outst[i] != '0;
      for (int k = NumAcc - 1; k >= 0; k--) begin
         if (w_cand[(int'(r_rr) + k) % NumAcc]) begin
            w_win   = IdxW'((int'(r_rr) + k) % NumAcc);
            w_grant = 1'b1;
         end
      end
      w_grant       = w_grant && w_out_free && !w_local;
      mst_p_ready_o = '0;
      mst_p_ready_o[w_win] = w_grant;
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_addr[r_wr] <= slv_q_addr_i;
         r_data[r_wr] <= slv_q_payload_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr        <= '0;
         r_rd        <= '0;
         r_cnt       <= '0;
         r_live      <= 1'b0;
         r_rr        <= '0;
         r_p_valid   <= 1'b0;
         r_p_err     <= 1'b0;
         r_p_payload <= '0;
         for (int i = 0; i < NumAcc; i++) r_outst[i] <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_push) r_wr <= r_wr == PtrW'(Depth - 1) ? '0 : r_wr + PtrW'(1);
         if (w_pop) r_rd <= r_rd == PtrW'(Depth - 1) ? '0 : r_rd + PtrW'(1);
         if (w_push != w_pop) r_cnt <= w_push ? r_cnt + CntW'(1) : r_cnt - CntW'(1);
         for (int i = 0; i < NumAcc; i++) begin
            if ((mst_q_valid_o[i] && mst_q_ready_i[i]) != (mst_p_ready_o[i] && mst_p_valid_i[i]))
               r_outst[i] <= (mst_q_valid_o[i] && mst_q_ready_i[i]) ? r_outst[i] + 4'd1 : r_outst[i] - 4'd1;
         end
         if (w_grant) r_rr <= w_win == IdxW'(NumAcc - 1) ? '0 : w_win + IdxW'(1);
         if (w_local || w_grant) begin
            r_p_valid   <= 1'b1;
            r_p_err     <= w_local;
            r_p_payload <= w_local ? '0 : mst_p_payload_i[int'(w_win)*RspWidth +: RspWidth];
         end else if (slv_p_ready_i) begin
            r_p_valid <= 1'b0;
            r_p_err   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_acc_c_dispatch.sv
// tb_acc_c_dispatch: vector table of single transactions plus hand sequences for
// outstanding limits, round-robin order, stray responses and mid-transaction reset.
module tb_acc_c_dispatch;
   localparam int NA = 4, AW = 3, QW = 96, RW = 69;

   logic               clk_i = 1'b0, rst_ni = 1'b0;
   logic               slv_q_valid_i = 1'b0, slv_q_ready_o;
   logic [AW-1:0]      slv_q_addr_i = '0;
   logic [QW-1:0]      slv_q_payload_i = '0;
   logic               slv_p_valid_o, slv_p_ready_i = 1'b1, slv_p_err_o;
   logic [RW-1:0]      slv_p_payload_o;
   logic [NA-1:0]      mst_q_valid_o, mst_q_ready_i = '1;
   logic [QW-1:0]      mst_q_payload_o;
   logic [NA-1:0]      mst_p_valid_i = '0, mst_p_ready_o;
   logic [NA*RW-1:0]   mst_p_payload_i = '0;

   acc_c_dispatch dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_q_valid_i(slv_q_valid_i), .slv_q_ready_o(slv_q_ready_o),
      .slv_q_addr_i(slv_q_addr_i), .slv_q_payload_i(slv_q_payload_i),
      .slv_p_valid_o(slv_p_valid_o), .slv_p_ready_i(slv_p_ready_i),
      .slv_p_payload_o(slv_p_payload_o), .slv_p_err_o(slv_p_err_o),
      .mst_q_valid_o(mst_q_valid_o), .mst_q_ready_i(mst_q_ready_i),
      .mst_q_payload_o(mst_q_payload_o),
      .mst_p_valid_i(mst_p_valid_i), .mst_p_ready_o(mst_p_ready_o),
      .mst_p_payload_i(mst_p_payload_i)
   );

   always #5 clk_i = ~clk_i;

   int total = 0, bad = 0, n_iss = 0;

   always @(negedge clk_i) if (rst_ni && |(mst_q_valid_o & mst_q_ready_i)) n_iss++;

   typedef struct {
      logic [2:0]    addr;
      logic [QW-1:0] qpay;
      logic [RW-1:0] ppay;
      logic [3:0]    exp_qv;
      logic          exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [2:0] a, input logic [QW-1:0] d);
      int k;
      k = 0;
      slv_q_valid_i = 1'b1;
      slv_q_addr_i = a;
      slv_q_payload_i = d;
      while (!slv_q_ready_o && k < 20) begin
         tick();
         k++;
      end
      if (k == 20) chk("push_timeout", slv_q_ready_o, 1);
      tick();
      slv_q_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      slv_q_valid_i = 1'b0;
      mst_p_valid_i = '0;
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic run_vec(input vec_t v);
      slv_q_valid_i = 1'b1;
      slv_q_addr_i = v.addr;
      slv_q_payload_i = v.qpay;
      tick();
      slv_q_valid_i = 1'b0;
      chk("q_valid", mst_q_valid_o, v.exp_qv);
      if (!v.exp_err) chk("q_payload", mst_q_payload_o, v.qpay);
      tick();
      chk("q_valid_after", mst_q_valid_o, 0);
      if (v.exp_err) begin
         chk("local_valid", slv_p_valid_o, 1);
         chk("local_err", slv_p_err_o, 1);
         chk("local_payload", slv_p_payload_o, 0);
      end else begin
         mst_p_valid_i[v.addr] = 1'b1;
         mst_p_payload_i[int'(v.addr)*RW +: RW] = v.ppay;
         #1;
         chk("p_ready", mst_p_ready_o, 4'b0001 << v.addr);
         tick();
         mst_p_valid_i = '0;
         chk("rsp_valid", slv_p_valid_o, 1);
         chk("rsp_payload", slv_p_payload_o, v.ppay);
         chk("rsp_err", slv_p_err_o, 0);
      end
      tick();
      chk("rsp_drained", slv_p_valid_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t          vecs[7];
      logic [3:0]    g[7];
      logic [RW-1:0] gp[7];
      int            base;
      vecs[0] = '{3'd2, 96'h0123_4567_89ab_cdef_0011_2233, 69'h1f_dead_beef_cafe_f00d, 4'b0100, 1'b0};
      vecs[1] = '{3'd0, 96'hffff_0000_ffff_0000_1234_5678, 69'h00_0000_0000_0000_0001, 4'b0001, 1'b0};
      vecs[2] = '{3'd3, 96'h5a5a_5a5a_a5a5_a5a5_5a5a_5a5a, 69'h10_0000_0000_0000_0000, 4'b1000, 1'b0};
      vecs[3] = '{3'd1, 96'h1, 69'h0a_5555_aaaa_5555_aaaa, 4'b0010, 1'b0};
      vecs[4] = '{3'd5, 96'hbad, 69'h0, 4'b0000, 1'b1};
      vecs[5] = '{3'd7, 96'hffff_ffff_ffff_ffff_ffff_ffff, 69'h0, 4'b0000, 1'b1};
      vecs[6] = '{3'd0, 96'h77, 69'h1234, 4'b0001, 1'b0};

      // reset values, with responses offered to prove they are ignored
      mst_p_valid_i = '1;
      tick();
      tick();
      chk("rst_q_ready", slv_q_ready_o, 0);
      chk("rst_p_valid", slv_p_valid_o, 0);
      chk("rst_p_err", slv_p_err_o, 0);
      chk("rst_mq_valid", mst_q_valid_o, 0);
      chk("rst_mp_ready", mst_p_ready_o, 0);
      mst_p_valid_i = '0;
      rst_ni = 1'b1;
      #1;
      chk("rel_q_ready_early", slv_q_ready_o, 0);
      tick();
      chk("rel_q_ready", slv_q_ready_o, 1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // port 2 now has nothing outstanding: its response must not be taken
      mst_p_valid_i = 4'b0100;
      mst_p_payload_i[2*RW +: RW] = 69'h1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stray_p_ready", mst_p_ready_o, 0);
         chk("stray_p_valid", slv_p_valid_o, 0);
         tick();
      end
      mst_p_valid_i = '0;

      // round-robin among ports 0,1,3 with two outstanding each
      do_reset();
      base = n_iss;
      push(3'd0, 96'h10);
      push(3'd1, 96'h11);
      push(3'd3, 96'h13);
      push(3'd0, 96'h20);
      push(3'd1, 96'h21);
      push(3'd3, 96'h23);
      repeat (3) tick();
      chk("rr_issued", n_iss - base, 6);
      mst_p_payload_i[0*RW +: RW] = 69'h100;
      mst_p_payload_i[1*RW +: RW] = 69'h101;
      mst_p_payload_i[3*RW +: RW] = 69'h103;
      g  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0000};
      gp = '{69'h100, 69'h101, 69'h103, 69'h100, 69'h101, 69'h103, 69'h0};
      mst_p_valid_i = 4'b1011;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("rr_grant", mst_p_ready_o, g[i]);
         if (i > 0) begin
            chk("rr_valid", slv_p_valid_o, 1);
            chk("rr_payload", slv_p_payload_o, gp[i-1]);
         end
         tick();
      end
      mst_p_valid_i = '0;
      tick();

      // outstanding limit on a silent port 1
      base = n_iss;
      for (int i = 0; i < 5; i++) push(3'd1, QW'(200 + i));
      repeat (3) tick();
      chk("lim_issued", n_iss - base, 3);
      chk("lim_q_ready", slv_q_ready_o, 0);
      chk("lim_mq_valid", mst_q_valid_o, 0);
      mst_p_valid_i = 4'b0010;
      mst_p_payload_i[1*RW +: RW] = 69'h0bee;
      #1;
      chk("lim_p_ready", mst_p_ready_o, 4'b0010);
      tick();
      mst_p_valid_i = '0;
      chk("lim_mq_valid_freed", mst_q_valid_o, 4'b0010);
      chk("lim_rsp_payload", slv_p_payload_o, 69'h0bee);
      tick();
      chk("lim_issued_after", n_iss - base, 4);
      chk("lim_q_ready_after", slv_q_ready_o, 1);
      chk("lim_mq_valid_after", mst_q_valid_o, 0);

      // asynchronous reset with FIFO full and port 1 outstanding
      push(3'd1, 96'h300);
      chk("pre_rst_q_ready", slv_q_ready_o, 0);
      base = n_iss;
      mst_p_valid_i = 4'b0010;
      #1;
      chk("pre_rst_p_ready", mst_p_ready_o, 4'b0010);
      rst_ni = 1'b0;
      #1;
      chk("arst_p_ready", mst_p_ready_o, 0);
      chk("arst_q_ready", slv_q_ready_o, 0);
      chk("arst_p_valid", slv_p_valid_o, 0);
      chk("arst_mq_valid", mst_q_valid_o, 0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      chk("post_rst_q_ready", slv_q_ready_o, 1);
      chk("post_rst_mq_valid", mst_q_valid_o, 0);
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_p_ready", mst_p_ready_o, 0);
         chk("post_rst_p_valid", slv_p_valid_o, 0);
         tick();
      end
      chk("post_rst_issued", n_iss - base, 0);
      mst_p_valid_i = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
